alu_sequencer: RTL

// Initiator side of the ALU operand/op/result interface. Accepts an operation request over a

---
 rtl/alu_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Initiator-side sequencer for the combinational ALU: accept, settle, capture Z, respond.
// Optional ALU_FLAGS_EN adds registered rsp_zero / rsp_neg result flags.
module alu_sequencer #(
    parameter int EXEC_CYCLES   = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_Y,
    output logic [31:0] alu_BusMuxOut,
    output logic [3:0]  alu_op,
    output logic        alu_enable,
    input  logic [63:0] alu_C,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg
`ifdef ALU_FLAGS_EN
    ,
    output logic        rsp_zero,
    output logic        rsp_neg
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_LAST = 4'd12;
    localparam logic [3:0] EXEC_N  = 4'(EXEC_CYCLES);
    localparam logic [3:0] MULDIV_N = 4'(MULDIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] y_q, y_d;
    logic [31:0] bus_q, bus_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        err_q, err_d;
    logic [31:0] hi_reg_q, hi_reg_d;
    logic [31:0] lo_reg_q, lo_reg_d;
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            y_q      <= '0;
            bus_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            err_q    <= 1'b0;
            hi_reg_q <= '0;
            lo_reg_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            y_q      <= y_d;
            bus_q    <= bus_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            err_q    <= err_d;
            hi_reg_q <= hi_reg_d;
            lo_reg_q <= lo_reg_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        y_d      = y_q;
        bus_d    = bus_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = err_q;
        hi_reg_d = hi_reg_q;
        lo_reg_d = lo_reg_q;
        zero_d   = zero_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d  = req_op;
                    y_d   = req_a;
                    bus_d = req_b;
                    if (req_op > OP_LAST) begin
                        lo_d    = '0;
                        hi_d    = '0;
                        err_d   = 1'b1;
                        zero_d  = 1'b0;
                        neg_d   = 1'b0;
                        count_d = '0;
                        state_d = RESP;
                    end else if (req_op == OP_DIV && req_b == '0) begin
                        // Divide-by-zero never reaches the ALU
                        lo_d    = '1;
                        hi_d    = req_a;
                        err_d   = 1'b1;
                        zero_d  = 1'b0;
                        neg_d   = 1'b0;
                        count_d = '0;
                        state_d = RESP;
                    end else begin
                        count_d = is_muldiv(req_op) ? MULDIV_N : EXEC_N;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                count_d = count_q - 4'd1;
                // <= also catches a zero count so EXEC can never stall
                if (count_q <= 4'd1) begin
                    count_d = '0;
                    lo_d    = alu_C[31:0];
                    hi_d    = alu_C[63:32];
                    err_d   = 1'b0;
                    zero_d  = (alu_C == 64'd0);
                    neg_d   = (op_q == OP_MUL) ? alu_C[63] : alu_C[31];
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (is_muldiv(op_q) && !err_q) begin
                        hi_reg_d = hi_q;
                        lo_reg_d = lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready     = clear && (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign alu_enable    = (state_q == EXEC);
    assign alu_Y         = y_q;
    assign alu_BusMuxOut = bus_q;
    assign alu_op        = op_q;
    assign rsp_lo        = lo_q;
    assign rsp_hi        = hi_q;
    assign rsp_err       = err_q;
    assign hi_reg        = hi_reg_q;
    assign lo_reg        = lo_reg_q;

`ifdef ALU_FLAGS_EN
    assign rsp_zero = zero_q;
    assign rsp_neg  = neg_q;
`else
    logic unused_flags;
    assign unused_flags = zero_q ^ neg_q;
`endif

endmodule
